// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: 64 lines of 8 words, single-cycle hit,
// burst line refill on miss with extra memory beats drained before the word is returned.
module icache (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] icache_rdaddr,
    input  logic        icache_rdreq,
    output logic [31:0] icache_dataout,
    output logic        icache_valid,
    output logic [31:0] mem_rdaddr,
    output logic        mem_rdreq,
    input  logic [31:0] mem_dataout,
    input  logic        mem_datavalid
);
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned NUM_LINES  = 64;
    localparam int unsigned OFF_W      = 3;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned TAG_W      = 21;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {IDLE, REQ, FILL, DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_LINES-1:0]  r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_LINES];
    logic [DATA_W-1:0]     r_data [NUM_LINES][LINE_WORDS];
    logic [31:2]           r_addr;
    logic [OFF_W-1:0]      r_cnt;

    logic [IDX_W-1:0]      w_req_idx;
    logic [OFF_W-1:0]      w_req_off;
    logic [TAG_W-1:0]      w_req_tag;
    logic [IDX_W-1:0]      w_fill_idx;
    logic [OFF_W-1:0]      w_fill_off;
    logic                  w_hit;
    logic                  w_latch;
    logic                  w_cnt_clr;
    logic                  w_beat_we;
    logic                  w_fill_done;
    logic                  w_valid_nxt;
    logic [DATA_W-1:0]     w_dout_nxt;
    logic                  w_mem_rdreq_nxt;
    logic                  w_unused_addr;

    assign w_req_idx     = icache_rdaddr[10:5];
    assign w_req_off     = icache_rdaddr[4:2];
    assign w_req_tag     = icache_rdaddr[31:11];
    assign w_fill_idx    = r_addr[10:5];
    assign w_fill_off    = r_addr[4:2];
    assign w_hit         = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_unused_addr = ^icache_rdaddr[1:0];

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_latch         = 1'b0;
        w_cnt_clr       = 1'b0;
        w_beat_we       = 1'b0;
        w_fill_done     = 1'b0;
        w_valid_nxt     = 1'b0;
        w_dout_nxt      = icache_dataout;
        w_mem_rdreq_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (icache_rdreq) begin
                    if (w_hit) begin
                        w_valid_nxt = 1'b1;
                        w_dout_nxt  = r_data[w_req_idx][w_req_off];
                    end else begin
                        w_latch         = 1'b1;
                        w_mem_rdreq_nxt = 1'b1;
                        w_state_nxt     = REQ;
                    end
                end
            end
            REQ: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = FILL;
            end
            FILL: begin
                if (mem_datavalid) begin
                    w_beat_we = 1'b1;
                    if (r_cnt == OFF_W'(LINE_WORDS - 1)) begin
                        w_fill_done = 1'b1;
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Surplus beats are swallowed; the word goes out on the first quiet cycle.
                if (!mem_datavalid) begin
                    w_valid_nxt = 1'b1;
                    w_dout_nxt  = r_data[w_fill_idx][w_fill_off];
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Registered outputs, miss bookkeeping and valid bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            icache_valid   <= 1'b0;
            icache_dataout <= '0;
            mem_rdreq      <= 1'b0;
            mem_rdaddr     <= '0;
            r_addr         <= '0;
            r_cnt          <= '0;
            r_valid        <= '0;
        end else begin
            icache_valid   <= w_valid_nxt;
            icache_dataout <= w_dout_nxt;
            mem_rdreq      <= w_mem_rdreq_nxt;
            if (w_latch) begin
                r_addr     <= icache_rdaddr[31:2];
                mem_rdaddr <= {icache_rdaddr[31:5], 5'b0};
                r_valid[w_req_idx] <= 1'b0;
            end
            if (w_cnt_clr)        r_cnt <= '0;
            else if (w_beat_we)   r_cnt <= r_cnt + OFF_W'(1);
            if (w_fill_done)      r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage, not reset; validity is carried by r_valid alone
    always_ff @(posedge clk) begin
        if (w_beat_we)   r_data[w_fill_idx][r_cnt] <= mem_dataout;
        if (w_fill_done) r_tag[w_fill_idx] <= r_addr[31:11];
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: burst memory model, hit/miss/conflict sequences,
// reset in the middle of a fill and ignored requests while busy.
module tb_icache;
    logic        clk;
    logic        reset_n;
    logic [31:0] icache_rdaddr;
    logic        icache_rdreq;
    logic [31:0] icache_dataout;
    logic        icache_valid;
    logic [31:0] mem_rdaddr;
    logic        mem_rdreq;
    logic [31:0] mem_dataout   = 32'd0;
    logic        mem_datavalid = 1'b0;
    logic        mem_busy      = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_memreq = 0;
    int n_valid  = 0;

    icache dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .icache_rdaddr  (icache_rdaddr),
        .icache_rdreq   (icache_rdreq),
        .icache_dataout (icache_dataout),
        .icache_valid   (icache_valid),
        .mem_rdaddr     (mem_rdaddr),
        .mem_rdreq      (mem_rdreq),
        .mem_dataout    (mem_dataout),
        .mem_datavalid  (mem_datavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Burst memory: 33 beats, first two = line base, beat k = base | (33-k)
    always begin
        logic [31:0] base;
        @(negedge clk);
        if (mem_rdreq === 1'b1) begin
            mem_busy = 1'b1;
            base = {mem_rdaddr[31:5], 5'd0};
            for (int k = 0; k < 33; k++) begin
                @(negedge clk);
                mem_datavalid = 1'b1;
                mem_dataout   = (k < 2) ? base : (base | 32'(33 - k));
            end
            @(negedge clk);
            mem_datavalid = 1'b0;
            mem_dataout   = 32'd0;
            mem_busy      = 1'b0;
        end
    end

    // Pulse counters
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_rdreq === 1'b1)    n_memreq++;
            if (icache_valid === 1'b1) n_valid++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_hit(input logic [31:0] a, input logic [31:0] exp);
        int mr0;
        mr0 = n_memreq;
        @(negedge clk);
        icache_rdaddr = a;
        icache_rdreq  = 1'b1;
        @(negedge clk);
        icache_rdreq  = 1'b0;
        check("hit_valid", 32'(icache_valid), 32'd1);
        check("hit_data", icache_dataout, exp);
        @(negedge clk);
        check("hit_single_pulse", 32'(icache_valid), 32'd0);
        check("hit_no_memreq", 32'(n_memreq - mr0), 32'd0);
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] exp, input bit inject);
        int mr0;
        int v0;
        bit seen;
        logic [31:0] d;
        mr0  = n_memreq;
        v0   = n_valid;
        seen = 1'b0;
        d    = 32'd0;
        @(negedge clk);
        icache_rdaddr = a;
        icache_rdreq  = 1'b1;
        @(negedge clk);
        icache_rdreq  = 1'b0;
        check("miss_no_early_valid", 32'(icache_valid), 32'd0);
        check("miss_memreq_pulse", 32'(mem_rdreq), 32'd1);
        check("miss_memaddr", mem_rdaddr, {a[31:5], 5'd0});
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (icache_valid === 1'b1) begin
                seen = 1'b1;
                d    = icache_dataout;
            end
            icache_rdreq  = inject && !seen && (i == 4 || i == 12 || i == 20);
            icache_rdaddr = a + 32'd4;
        end
        icache_rdreq = 1'b0;
        check("miss_valid_seen", 32'(seen), 32'd1);
        check("miss_data", d, exp);
        repeat (2) @(negedge clk);
        check("miss_one_valid", 32'(n_valid - v0), 32'd1);
        check("miss_one_memreq", 32'(n_memreq - mr0), 32'd1);
        check("miss_mem_idle", 32'(mem_busy), 32'd0);
    endtask

    initial begin
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_exp  [4];
        int mr0;
        int v0;
        bit idle;

        reset_n       = 1'b0;
        icache_rdreq  = 1'b0;
        icache_rdaddr = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(icache_valid), 32'd0);
        check("rst_dataout", icache_dataout, 32'd0);
        check("rst_memreq", 32'(mem_rdreq), 32'd0);
        check("rst_memaddr", mem_rdaddr, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Cold miss then hits on the filled line
        do_miss(32'h0000_0000, 32'h0000_0000, 1'b0);
        do_hit(32'h0000_0000, 32'h0000_0000);
        do_hit(32'h0000_0004, 32'h0000_0000);

        // Four hits on consecutive cycles
        b2b_addr = '{32'h08, 32'h0C, 32'h10, 32'h18};
        b2b_exp  = '{32'h1F, 32'h1E, 32'h1D, 32'h1B};
        mr0 = n_memreq;
        @(negedge clk);
        icache_rdaddr = b2b_addr[0];
        icache_rdreq  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_valid", 32'(icache_valid), 32'd1);
            check("b2b_data", icache_dataout, b2b_exp[i]);
            if (i < 3) icache_rdaddr = b2b_addr[i + 1];
            else       icache_rdreq  = 1'b0;
        end
        @(negedge clk);
        check("b2b_end_valid", 32'(icache_valid), 32'd0);
        check("b2b_no_memreq", 32'(n_memreq - mr0), 32'd0);

        // Conflict on index 0
        do_miss(32'h2000_0000, 32'h2000_0000, 1'b0);
        do_hit(32'h2000_0008, 32'h2000_001F);
        do_miss(32'h0000_0000, 32'h0000_0000, 1'b0);

        // Reset during a fill of line 0x40
        v0  = n_valid;
        mr0 = n_memreq;
        @(negedge clk);
        icache_rdaddr = 32'h0000_0040;
        icache_rdreq  = 1'b1;
        @(negedge clk);
        icache_rdreq  = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(icache_valid), 32'd0);
        check("midrst_memreq", 32'(mem_rdreq), 32'd0);
        check("midrst_memaddr", mem_rdaddr, 32'd0);
        check("midrst_dataout", icache_dataout, 32'd0);
        reset_n = 1'b1;
        idle = 1'b0;
        for (int i = 0; i < 80 && !idle; i++) begin
            @(posedge clk);
            if (!mem_busy) idle = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("midrst_mem_drained", 32'(idle), 32'd1);
        check("midrst_no_valid", 32'(n_valid - v0), 32'd0);
        check("midrst_one_memreq", 32'(n_memreq - mr0), 32'd1);

        // Interrupted line must miss again; requests during the fill are dropped
        do_miss(32'h0000_0040, 32'h0000_0040, 1'b1);
        do_hit(32'h0000_0044, 32'h0000_0040);
        do_hit(32'h0000_0048, 32'h0000_005F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
